mem_port_arbiter: RTL and testbench

Arbitrates one single-port synchronous data SRAM between the instruction-fetch requester (IF) and the data-memory requester (EXE loads / MEM stores). Issues at most one SRAM access per cycle with fixed one-cycle read latency, and tags each read so its response returns to the requester that issued it. Sits between the pipeline stages and the SRAM macro. Replaces the ad-hoc `prev_mem_re` load stall with explicit grant/response handshakes.

---
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port SRAM arbiter between instruction fetch (IF) and data memory (DM): one access per cycle,
// one-cycle read latency, responses tagged back to their issuer. Define MEM_ARB_RR_EN for round-robin.
module mem_port_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [3:0]        dm_wstrb,
    input  logic [31:0]       dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [31:0]       dm_rdata,
    output logic              sram_en,
    output logic [3:0]        sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);
    // Handshake: a requester raises req with its payload and holds both stable until gnt is seen in the
    // same cycle; the SRAM access happens in that cycle and a read returns rvalid exactly one cycle later.
    // rvalid has no ready: the requester must take the data in that cycle.

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_t;

    owner_t rsp_owner;
    owner_t rsp_owner_nxt;
    logic   if_wins;

`ifdef MEM_ARB_RR_EN
    logic last_gnt_dm;
    logic last_gnt_dm_nxt;

    // After a DM grant, IF takes the next contested cycle, and vice versa.
    assign if_wins = last_gnt_dm;

    always_comb begin
        last_gnt_dm_nxt = last_gnt_dm;
        if (dm_gnt) begin
            last_gnt_dm_nxt = 1'b1;
        end else if (if_gnt) begin
            last_gnt_dm_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_gnt_dm <= 1'b0;
        end else begin
            last_gnt_dm <= last_gnt_dm_nxt;
        end
    end
`else
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;
    logic [3:0] starve_cnt_nxt;

    assign if_wins = (starve_cnt == STARVE_LIM);

    always_comb begin
        starve_cnt_nxt = 4'd0;
        if (if_req && !if_gnt) begin
            starve_cnt_nxt = (starve_cnt == STARVE_LIM) ? starve_cnt : starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
        end else begin
            starve_cnt <= starve_cnt_nxt;
        end
    end
`endif

    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (rst_n) begin
            if (if_req && dm_req) begin
                if_gnt = if_wins;
                dm_gnt = !if_wins;
            end else begin
                if_gnt = if_req;
                dm_gnt = dm_req;
            end
        end
    end

    // The SRAM port is zeroed whenever nobody holds it, so idle cycles show no stale payload.
    always_comb begin
        sram_en    = if_gnt | dm_gnt;
        sram_we    = 4'b0000;
        sram_addr  = '0;
        sram_wdata = 32'd0;
        if (if_gnt) begin
            sram_addr = if_addr[ADDR_W+1:2];
        end else if (dm_gnt) begin
            sram_addr  = dm_addr[ADDR_W+1:2];
            sram_wdata = dm_wdata;
            if (dm_we) begin
                sram_we = dm_wstrb;
            end
        end
    end

    always_comb begin
        rsp_owner_nxt = OWN_NONE;
        if (if_gnt) begin
            rsp_owner_nxt = OWN_IF;
        end else if (dm_gnt && !dm_we) begin
            rsp_owner_nxt = OWN_DM;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_owner <= OWN_NONE;
        end else begin
            rsp_owner <= rsp_owner_nxt;
        end
    end

    // A flush only kills the fetch response due now; a fetch granted this cycle is unaffected.
    assign if_rvalid = (rsp_owner == OWN_IF) && !if_flush;
    assign dm_rvalid = (rsp_owner == OWN_DM);
    assign if_rdata  = if_rvalid ? sram_rdata : 32'd0;
    assign dm_rdata  = dm_rvalid ? sram_rdata : 32'd0;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0], dm_addr[31:ADDR_W+2], dm_addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(if_gnt && dm_gnt));
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus held-request random traffic,
// checked against a cycle-level reference model and a behavioural SRAM.
module tb_mem_port_arbiter;
    localparam int ADDR_W     = 14;
    localparam int STARVE_MAX = 4;
    localparam int DEPTH      = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              if_req = 1'b0;
    logic [31:0]       if_addr = 32'd0;
    logic              if_flush = 1'b0;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              dm_req = 1'b0;
    logic              dm_we = 1'b0;
    logic [3:0]        dm_wstrb = 4'd0;
    logic [31:0]       dm_addr = 32'd0;
    logic [31:0]       dm_wdata = 32'd0;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [31:0]       dm_rdata;
    logic              sram_en;
    logic [3:0]        sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_wdata;
    logic [31:0]       sram_rdata = 32'd0;

    int n_pass = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_wstrb(dm_wstrb), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata)
    );

    function automatic logic [31:0] pat(input int a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Behavioural SRAM attached to the DUT's port.
    logic [31:0] sram_mem [DEPTH];
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we == 4'b0000) begin
                sram_rdata <= sram_mem[sram_addr];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (sram_we[b]) sram_mem[sram_addr][8*b +: 8] = sram_wdata[8*b +: 8];
            end
        end
    end

    // Reference model: arbitration rules, pending response and the memory contents it expects.
    logic [31:0]       ref_mem [DEPTH];
    int                m_starve = 0;
    bit                m_last_dm = 1'b0;
    int                m_pend = 0;           // 0 none, 1 IF, 2 DM
    logic [31:0]       m_pend_data = 32'd0;
    logic              e_if_gnt, e_dm_gnt, e_en, e_if_rv, e_dm_rv;
    logic [3:0]        e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [31:0]       e_wdata, e_if_rd, e_dm_rd;

    function void predict();
        e_if_gnt = 1'b0;
        e_dm_gnt = 1'b0;
        if (rst_n) begin
            if (if_req && dm_req) begin
`ifdef MEM_ARB_RR_EN
                e_if_gnt = m_last_dm;
`else
                e_if_gnt = (m_starve >= STARVE_MAX);
`endif
                e_dm_gnt = !e_if_gnt;
            end else begin
                e_if_gnt = if_req;
                e_dm_gnt = dm_req;
            end
        end
        e_en = e_if_gnt | e_dm_gnt;
        e_addr = '0;
        e_we = 4'd0;
        e_wdata = 32'd0;
        if (e_if_gnt) begin
            e_addr = if_addr[ADDR_W+1:2];
        end else if (e_dm_gnt) begin
            e_addr = dm_addr[ADDR_W+1:2];
            e_wdata = dm_wdata;
            if (dm_we) e_we = dm_wstrb;
        end
        e_if_rv = (m_pend == 1) && !if_flush;
        e_dm_rv = (m_pend == 2);
        e_if_rd = e_if_rv ? m_pend_data : 32'd0;
        e_dm_rd = e_dm_rv ? m_pend_data : 32'd0;
    endfunction

    function void commit();
        logic [ADDR_W-1:0] a;
        if (!rst_n) begin
            m_starve = 0;
            m_last_dm = 1'b0;
            m_pend = 0;
        end else begin
            if (if_req && !e_if_gnt) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
            else m_starve = 0;
            if (e_if_gnt) m_last_dm = 1'b0;
            else if (e_dm_gnt) m_last_dm = 1'b1;
            m_pend = 0;
            if (e_if_gnt) begin
                a = if_addr[ADDR_W+1:2];
                m_pend = 1;
                m_pend_data = ref_mem[a];
            end else if (e_dm_gnt && !dm_we) begin
                a = dm_addr[ADDR_W+1:2];
                m_pend = 2;
                m_pend_data = ref_mem[a];
            end else if (e_dm_gnt) begin
                a = dm_addr[ADDR_W+1:2];
                for (int b = 0; b < 4; b++)
                    if (dm_wstrb[b]) ref_mem[a][8*b +: 8] = dm_wdata[8*b +: 8];
            end
        end
    endfunction

    task automatic drive_all(input logic ifr, input logic [31:0] ia, input logic fl, input logic dmr,
                             input logic we, input logic [3:0] st, input logic [31:0] da, input logic [31:0] wd);
        if_req = ifr; if_addr = ia; if_flush = fl;
        dm_req = dmr; dm_we = we; dm_wstrb = st; dm_addr = da; dm_wdata = wd;
    endtask

    task automatic release_cycle();
        @(negedge clk);
        rst_n = 1'b1;
        drive_all(0, 0, 0, 0, 0, 0, 0, 0);
        #1; predict(); commit();
        @(posedge clk);
    endtask

    task automatic apply_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst_n = 1'b0;
            drive_all(0, 0, 0, 0, 0, 0, 0, 0);
            #1; predict(); commit();
            @(posedge clk);
        end
        release_cycle();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rst_n = 1'b0;
            drive_all(1, 32'h100, 0, 1, 0, 4'hF, 32'h200, 32'h1234);
            #1; predict();
            n_checks++; if (if_gnt !== 1'b0) $display("FAIL reset_if_gnt got %b exp 0", if_gnt); else n_pass++;
            n_checks++; if (dm_gnt !== 1'b0) $display("FAIL reset_dm_gnt got %b exp 0", dm_gnt); else n_pass++;
            n_checks++; if (sram_en !== 1'b0) $display("FAIL reset_sram_en got %b exp 0", sram_en); else n_pass++;
            n_checks++;
            if ({sram_we, sram_addr, sram_wdata} !== '0) $display("FAIL reset_sram_bus got we=%h addr=%h wdata=%h exp 0", sram_we, sram_addr, sram_wdata);
            else n_pass++;
            n_checks++;
            if ({if_rvalid, dm_rvalid, if_rdata, dm_rdata} !== '0)
                $display("FAIL reset_rsp got ifv=%b dmv=%b ifd=%h dmd=%h exp 0", if_rvalid, dm_rvalid, if_rdata, dm_rdata);
            else n_pass++;
            commit();
            @(posedge clk);
        end
        release_cycle();
    endtask

    task automatic test_if_read();
        @(negedge clk);
        drive_all(1, 32'h100, 0, 0, 0, 0, 0, 0);
        #1; predict();
        n_checks++; if (if_gnt !== 1'b1) $display("FAIL if_read_gnt got %b exp 1", if_gnt); else n_pass++;
        n_checks++; if (sram_en !== 1'b1) $display("FAIL if_read_en got %b exp 1", sram_en); else n_pass++;
        n_checks++; if (sram_addr !== 14'h40) $display("FAIL if_read_addr got %h exp 40", sram_addr); else n_pass++;
        n_checks++; if (sram_we !== 4'h0) $display("FAIL if_read_we got %h exp 0", sram_we); else n_pass++;
        commit();
        @(posedge clk);
        @(negedge clk);
        drive_all(0, 0, 0, 0, 0, 0, 0, 0);
        #1; predict();
        n_checks++; if (if_rvalid !== 1'b1) $display("FAIL if_read_rvalid got %b exp 1", if_rvalid); else n_pass++;
        n_checks++; if (if_rdata !== pat(32'h40)) $display("FAIL if_read_rdata got %h exp %h", if_rdata, pat(32'h40)); else n_pass++;
        n_checks++; if (dm_rvalid !== 1'b0) $display("FAIL if_read_dm_rvalid got %b exp 0", dm_rvalid); else n_pass++;
        commit();
        @(posedge clk);
    endtask

    task automatic test_dm_store();
        logic [31:0] orig, exp_word;
        orig = pat(2);
        exp_word = {orig[31:16], 16'hBEEF};
        @(negedge clk);
        drive_all(0, 0, 0, 1, 1, 4'b0011, 32'h8, 32'hDEADBEEF);
        #1; predict();
        n_checks++; if (dm_gnt !== 1'b1) $display("FAIL store_gnt got %b exp 1", dm_gnt); else n_pass++;
        n_checks++; if (sram_we !== 4'b0011) $display("FAIL store_we got %b exp 0011", sram_we); else n_pass++;
        n_checks++; if (sram_addr !== 14'h2) $display("FAIL store_addr got %h exp 2", sram_addr); else n_pass++;
        n_checks++; if (sram_wdata !== 32'hDEADBEEF) $display("FAIL store_wdata got %h exp deadbeef", sram_wdata); else n_pass++;
        commit();
        @(posedge clk);
        @(negedge clk);
        drive_all(0, 0, 0, 1, 0, 4'hF, 32'h8, 32'h0);
        #1; predict();
        n_checks++; if (dm_rvalid !== 1'b0) $display("FAIL store_no_rvalid got %b exp 0", dm_rvalid); else n_pass++;
        n_checks++; if (sram_we !== 4'b0000) $display("FAIL load_we got %b exp 0000", sram_we); else n_pass++;
        commit();
        @(posedge clk);
        @(negedge clk);
        drive_all(0, 0, 0, 0, 0, 0, 0, 0);
        #1; predict();
        n_checks++; if (dm_rvalid !== 1'b1) $display("FAIL load_rvalid got %b exp 1", dm_rvalid); else n_pass++;
        n_checks++; if (dm_rdata !== exp_word) $display("FAIL load_merged_rdata got %h exp %h", dm_rdata, exp_word); else n_pass++;
        commit();
        @(posedge clk);
    endtask

    task automatic test_starvation();
        logic exp_if;
        apply_reset(1);
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            drive_all(1, 32'h200 + 32'(4 * k), 0, 1, 0, 4'hF, 32'h300 + 32'(4 * k), 0);
            #1; predict();
`ifdef MEM_ARB_RR_EN
            exp_if = (k % 2) == 1;
`else
            exp_if = (k % 5) == 4;
`endif
            n_checks++; if (if_gnt !== exp_if) $display("FAIL starve_if_gnt k=%0d got %b exp %b", k, if_gnt, exp_if); else n_pass++;
            n_checks++; if (dm_gnt !== !exp_if) $display("FAIL starve_dm_gnt k=%0d got %b exp %b", k, dm_gnt, !exp_if); else n_pass++;
            n_checks++;
            if (if_rvalid !== e_if_rv || dm_rvalid !== e_dm_rv || if_rdata !== e_if_rd || dm_rdata !== e_dm_rd)
                $display("FAIL starve_rsp k=%0d got %b%b %h %h exp %b%b %h %h", k, if_rvalid, dm_rvalid, if_rdata, dm_rdata,
                         e_if_rv, e_dm_rv, e_if_rd, e_dm_rd);
            else n_pass++;
            commit();
            @(posedge clk);
        end
    endtask

    task automatic test_flush();
        release_cycle();
        @(negedge clk);
        drive_all(1, 32'h44, 0, 0, 0, 0, 0, 0);
        #1; predict();
        n_checks++; if (if_gnt !== 1'b1) $display("FAIL flush_if_gnt got %b exp 1", if_gnt); else n_pass++;
        commit();
        @(posedge clk);
        @(negedge clk);
        drive_all(0, 0, 1, 1, 0, 4'hF, 32'h48, 0);
        #1; predict();
        n_checks++; if (if_rvalid !== 1'b0) $display("FAIL flush_kill_rvalid got %b exp 0", if_rvalid); else n_pass++;
        n_checks++; if (if_rdata !== 32'd0) $display("FAIL flush_kill_rdata got %h exp 0", if_rdata); else n_pass++;
        n_checks++; if (dm_gnt !== 1'b1) $display("FAIL flush_dm_gnt got %b exp 1", dm_gnt); else n_pass++;
        commit();
        @(posedge clk);
        @(negedge clk);
        drive_all(1, 32'h4C, 1, 0, 0, 0, 0, 0);
        #1; predict();
        n_checks++; if (dm_rvalid !== 1'b1) $display("FAIL flush_dm_rvalid got %b exp 1", dm_rvalid); else n_pass++;
        n_checks++; if (dm_rdata !== pat(32'h12)) $display("FAIL flush_dm_rdata got %h exp %h", dm_rdata, pat(32'h12)); else n_pass++;
        n_checks++; if (if_gnt !== 1'b1) $display("FAIL flush_same_cycle_gnt got %b exp 1", if_gnt); else n_pass++;
        commit();
        @(posedge clk);
        @(negedge clk);
        drive_all(0, 0, 0, 0, 0, 0, 0, 0);
        #1; predict();
        n_checks++; if (if_rvalid !== 1'b1) $display("FAIL flush_next_rvalid got %b exp 1", if_rvalid); else n_pass++;
        n_checks++; if (if_rdata !== pat(32'h13)) $display("FAIL flush_next_rdata got %h exp %h", if_rdata, pat(32'h13)); else n_pass++;
        commit();
        @(posedge clk);
    endtask

    task automatic test_reset_inflight();
        @(negedge clk);
        drive_all(0, 0, 0, 1, 0, 4'hF, 32'h50, 0);
        #1; predict();
        n_checks++; if (dm_gnt !== 1'b1) $display("FAIL rst_inflight_gnt got %b exp 1", dm_gnt); else n_pass++;
        rst_n = 1'b0;
        #1; predict();
        n_checks++; if (dm_gnt !== 1'b0 || sram_en !== 1'b0) $display("FAIL rst_forced_gnt got gnt=%b en=%b exp 0", dm_gnt, sram_en); else n_pass++;
        commit();
        @(posedge clk);
        @(negedge clk);
        drive_all(0, 0, 0, 0, 0, 0, 0, 0);
        #1; predict();
        n_checks++; if (dm_rvalid !== 1'b0) $display("FAIL rst_dropped_rvalid got %b exp 0", dm_rvalid); else n_pass++;
        n_checks++;
        if ({if_gnt, dm_gnt, if_rvalid, if_rdata, dm_rdata, sram_en, sram_we, sram_addr, sram_wdata} !== '0)
            $display("FAIL rst_all_zero got ifg=%b dmg=%b ifv=%b ifd=%h dmd=%h en=%b we=%h a=%h wd=%h exp 0",
                     if_gnt, dm_gnt, if_rvalid, if_rdata, dm_rdata, sram_en, sram_we, sram_addr, sram_wdata);
        else n_pass++;
        commit();
        @(posedge clk);
        release_cycle();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            if (k == 12) drive_all(0, 0, 0, 0, 0, 0, 0, 0);
            else if (k % 2 == 0) drive_all(1, $urandom(), 0, 0, 0, 0, 0, 0);
            else drive_all(0, 0, 0, 1, 0, 4'hF, $urandom(), $urandom());
            #1; predict();
            if (k < 12) begin
                n_checks++;
                if (if_gnt !== (k % 2 == 0) || dm_gnt !== (k % 2 == 1))
                    $display("FAIL b2b_gnt k=%0d got %b%b exp %b%b", k, if_gnt, dm_gnt, k % 2 == 0, k % 2 == 1);
                else n_pass++;
            end
            if (k > 0) begin
                n_checks++;
                if (if_rvalid !== (k % 2 == 1) || dm_rvalid !== (k % 2 == 0))
                    $display("FAIL b2b_rvalid k=%0d got %b%b exp %b%b", k, if_rvalid, dm_rvalid, k % 2 == 1, k % 2 == 0);
                else n_pass++;
                n_checks++;
                if (if_rdata !== e_if_rd || dm_rdata !== e_dm_rd)
                    $display("FAIL b2b_rdata k=%0d got %h %h exp %h %h", k, if_rdata, dm_rdata, e_if_rd, e_dm_rd);
                else n_pass++;
            end
            commit();
            @(posedge clk);
        end
    endtask

    task automatic test_random();
        logic r_if = 1'b0, r_dm = 1'b0, r_we = 1'b0;
        logic [3:0] r_st = 4'd0;
        logic [31:0] r_ia = 32'd0, r_da = 32'd0, r_wd = 32'd0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (!r_if && $urandom_range(0, 2) != 0) begin r_if = 1'b1; r_ia = $urandom(); end
            if (!r_dm && $urandom_range(0, 2) != 0) begin
                r_dm = 1'b1; r_we = $urandom_range(0, 1) == 1; r_st = 4'($urandom_range(0, 15));
                r_da = {$urandom_range(0, 3) == 0 ? r_ia[31:4] : 28'($urandom()), 4'($urandom())};
                r_wd = $urandom();
            end
            rst_n = $urandom_range(0, 59) != 0;
            drive_all(r_if, r_ia, $urandom_range(0, 7) == 0, r_dm, r_we, r_st, r_da, r_wd);
            #1; predict();
            n_checks++;
            if (if_gnt !== e_if_gnt || dm_gnt !== e_dm_gnt)
                $display("FAIL rnd_gnt k=%0d got %b%b exp %b%b", k, if_gnt, dm_gnt, e_if_gnt, e_dm_gnt);
            else n_pass++;
            n_checks++;
            if (sram_en !== e_en || sram_we !== e_we || sram_addr !== e_addr || sram_wdata !== e_wdata)
                $display("FAIL rnd_sram k=%0d got %b %h %h %h exp %b %h %h %h", k, sram_en, sram_we, sram_addr, sram_wdata,
                         e_en, e_we, e_addr, e_wdata);
            else n_pass++;
            n_checks++;
            if (if_rvalid !== e_if_rv || if_rdata !== e_if_rd)
                $display("FAIL rnd_if_rsp k=%0d got %b %h exp %b %h", k, if_rvalid, if_rdata, e_if_rv, e_if_rd);
            else n_pass++;
            n_checks++;
            if (dm_rvalid !== e_dm_rv || dm_rdata !== e_dm_rd)
                $display("FAIL rnd_dm_rsp k=%0d got %b %h exp %b %h", k, dm_rvalid, dm_rdata, e_dm_rv, e_dm_rd);
            else n_pass++;
            commit();
            if (e_if_gnt) r_if = 1'b0;
            if (e_dm_gnt) r_dm = 1'b0;
            @(posedge clk);
        end
        release_cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout bench did not finish within 2 ms");
        $fatal(1, "timeout");
    end

    initial begin
        for (int a = 0; a < DEPTH; a++) begin
            sram_mem[a] = pat(a);
            ref_mem[a] = pat(a);
        end
        test_reset();
        test_if_read();
        test_dm_store();
        test_starvation();
        test_flush();
        test_reset_inflight();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
